// File: rtl/tdm_demux_1to4_pkg.sv
// ----------------------------------------------------------------------------
// tdm_demux_1to4_pkg
// Shared definitions for the 1-to-4 TDM demultiplexer:
//   state_e   - framing FSM encoding (HUNT, RUN)
//   CH_A..D   - channel indices carried on sel (0..3)
//   ERRCNT_W  - width of the optional framing-error counter
// ----------------------------------------------------------------------------
package tdm_demux_1to4_pkg;

    typedef enum logic {
        HUNT = 1'b0,   // waiting for a sync-flagged channel-A sample
        RUN  = 1'b1    // frame alignment acquired
    } state_e;

    localparam logic [1:0] CH_A = 2'd0;
    localparam logic [1:0] CH_B = 2'd1;
    localparam logic [1:0] CH_C = 2'd2;
    localparam logic [1:0] CH_D = 2'd3;

    localparam int ERRCNT_W = 8;

endpackage : tdm_demux_1to4_pkg

// File: rtl/tdm_demux_1to4_chan_counter.sv
// ----------------------------------------------------------------------------
// chan_counter
// 2-bit wrapping channel counter. load_one forces the count to channel B
// (the sample just accepted was channel A); otherwise inc advances it,
// wrapping from D back to A.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset (count -> CH_A)
//   load_one    - synchronous load of 1, has priority over inc
//   inc         - increment enable
//   cnt         - current channel index
// ----------------------------------------------------------------------------
module chan_counter
    import tdm_demux_1to4_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_one,
    input  logic       inc,
    output logic [1:0] cnt
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= CH_A;
        end else if (load_one) begin
            cnt <= CH_B;
        end else if (inc) begin
            cnt <= cnt + 2'd1;   // natural 2-bit wrap D -> A
        end
    end

endmodule : chan_counter

// File: rtl/tdm_demux_1to4.sv
// ----------------------------------------------------------------------------
// tdm_demux_1to4
// Splits a serial time-division stream (channel order A,B,C,D) into four
// registered parallel outputs. A sync flag on a valid sample marks channel A.
// Samples A..C are held in shadow registers; the channel-D sample commits the
// whole frame to dout_a..dout_d in one edge, so the outputs always show one
// complete, coherent frame.
//
// Optional feature macro: TDM_DEMUX_ERRCNT_EN adds a saturating framing-error
// counter on port err_count.
//
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   din, din_valid    - sample stream and its qualifier
//   sync              - channel-A marker (only meaningful with din_valid)
//   dout_a..dout_d    - last complete frame
//   frame_valid       - one-cycle pulse when dout_* update
//   sel               - channel index the next accepted sample goes to
//   locked            - high while frame alignment is held (RUN)
//   frame_err         - one-cycle pulse when sync arrives mid-frame
//   err_count         - framing-error count (TDM_DEMUX_ERRCNT_EN only)
// ----------------------------------------------------------------------------
module tdm_demux_1to4
    import tdm_demux_1to4_pkg::*;
#(
    parameter int W = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [W-1:0]        din,
    input  logic                din_valid,
    input  logic                sync,
    output logic [W-1:0]        dout_a,
    output logic [W-1:0]        dout_b,
    output logic [W-1:0]        dout_c,
    output logic [W-1:0]        dout_d,
    output logic                frame_valid,
    output logic [1:0]          sel,
    output logic                locked,
    output logic                frame_err
`ifdef TDM_DEMUX_ERRCNT_EN
    ,
    output logic [ERRCNT_W-1:0] err_count
`endif
);

    state_e       state, state_next;
    logic         load_one, inc;
    logic         wr_a, wr_b, wr_c;
    logic         frame_done, err_hit;
    logic [W-1:0] shadow_a, shadow_b, shadow_c;

    chan_counter u_chan_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_one (load_one),
        .inc      (inc),
        .cnt      (sel)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HUNT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and per-sample control. Nothing happens without din_valid.
    // NOTE: every signal driven here gets a default first; a path that left
    // one unassigned would infer a latch.
    always_comb begin
        state_next = state;
        load_one   = 1'b0;
        inc        = 1'b0;
        wr_a       = 1'b0;
        wr_b       = 1'b0;
        wr_c       = 1'b0;
        frame_done = 1'b0;
        err_hit    = 1'b0;

        if (din_valid) begin
            if (state == HUNT) begin
                if (sync) begin
                    wr_a       = 1'b1;
                    load_one   = 1'b1;
                    state_next = RUN;
                end
            end else if (sync && (sel != CH_A)) begin
                // Sync mid-frame: drop the partial frame and restart it
                // with this sample as channel A.
                err_hit  = 1'b1;
                wr_a     = 1'b1;
                load_one = 1'b1;
            end else begin
                // At CH_A the sample is taken as channel A whatever sync says.
                inc = 1'b1;
                unique case (sel)
                    CH_A: wr_a       = 1'b1;
                    CH_B: wr_b       = 1'b1;
                    CH_C: wr_c       = 1'b1;
                    CH_D: frame_done = 1'b1;
                endcase
            end
        end
    end

    // NOTE: the shadow and output registers are reset along with the control
    // state so a frame started before reset can never leak onto dout_*.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_a    <= '0;
            shadow_b    <= '0;
            shadow_c    <= '0;
            dout_a      <= '0;
            dout_b      <= '0;
            dout_c      <= '0;
            dout_d      <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_valid <= frame_done;
            frame_err   <= err_hit;
            if (wr_a) shadow_a <= din;
            if (wr_b) shadow_b <= din;
            if (wr_c) shadow_c <= din;
            if (frame_done) begin
                dout_a <= shadow_a;
                dout_b <= shadow_b;
                dout_c <= shadow_c;
                dout_d <= din;   // channel D goes straight to the output
            end
        end
    end

    assign locked = (state == RUN);

`ifdef TDM_DEMUX_ERRCNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (err_hit && (err_count != '1)) begin
            err_count <= err_count + ERRCNT_W'(1);   // saturates at all-ones
        end
    end
`endif

endmodule : tdm_demux_1to4

// File: doc/tdm_demux_1to4.md
TDM_DEMUX_1TO4 -- requirements
Module: tdm_demux_1to4

Interface
REQ-001 Parameter W, default 1: data width of each channel sample.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 din  input  W  serial time-division sample stream, channel order A,B,C,D.
REQ-005 din_valid  input  1  din carries a sample this cycle.
REQ-006 sync  input  1  frame marker, meaningful only with din_valid; flags the channel-A sample.
REQ-007 dout_a, dout_b, dout_c, dout_d  output  W each  last complete frame, registered.
REQ-008 frame_valid  output  1  one-cycle pulse when all four douts update.
REQ-009 sel  output  2  channel index the next accepted sample is written to (0=A..3=D).
REQ-010 locked  output  1  high in RUN state.
REQ-011 frame_err  output  1  one-cycle pulse on a framing error.
REQ-012 err_count  output  8  framing-error count; present only under TDM_DEMUX_ERRCNT_EN.

Function
REQ-013 Two-state FSM, HUNT and RUN, plus a 2-bit channel counter (sel) and three W-bit shadow registers for A, B and C.
REQ-014 Cycles with din_valid=0 change no state; sync is ignored in those cycles.
REQ-015 HUNT: a sample with sync=0 is discarded and sel stays 0.
REQ-016 HUNT: a sample with sync=1 is written to shadow A, sel becomes 1 and the FSM enters RUN.
REQ-017 RUN, sel=0: a sample is written to shadow A whatever the value of sync, and sel becomes 1.
REQ-018 RUN, sel=1 or 2 with sync=0: the sample is written to shadow B or C, and sel increments.
REQ-019 RUN, sel=3 with sync=0, same edge:
- dout_a..dout_c load from shadows A..C and dout_d loads din.
- frame_valid pulses for that cycle.
- sel wraps to 0.
REQ-020 RUN, sel not 0 with sync=1 (framing error), same edge:
- frame_err pulses.
- the partial frame is dropped and douts hold.
- the sample is written to shadow A, sel becomes 1, and the FSM stays in RUN.
REQ-021 Latency: douts and frame_valid become visible one clock after the channel-D sample edge; douts hold until the next complete frame.
REQ-022 frame_valid and frame_err are never high in the same cycle.

Reset
REQ-023 When rst_n is low, on its asynchronous assertion:
- FSM goes to HUNT and sel to 0.
- shadows, dout_a..dout_d and err_count go to 0.
- frame_valid, frame_err and locked go to 0.
REQ-024 Reset mid-frame discards the partial frame; after release the block hunts for sync again.

Configuration
REQ-025 When TDM_DEMUX_ERRCNT_EN is defined:
- err_count is a port.
- it increments on each frame_err pulse and saturates at 255.
- it clears only on reset.
REQ-026 Without TDM_DEMUX_ERRCNT_EN, err_count and its register are absent; all other behaviour is identical.

Structure
REQ-027 The shared package holds:
- the FSM state encoding (HUNT, RUN).
- the channel index constants CH_A..CH_D = 0..3.
- the counter width constant ERRCNT_W = 8.
REQ-028 Sub-module chan_counter: a 2-bit wrapping counter with a synchronous load-to-1 input and an increment enable; it drives sel.

Verification
REQ-029 Reset, then A,B,C,D = 1,0,0,0 with sync on A, all valid -> one clock after D, douts = 1,0,0,0, frame_valid pulses once, locked=1.
REQ-030 Back-to-back frames 0,1,0,0 then 0,0,1,0, sync on each A -> two frame_valid pulses four cycles apart, douts follow each frame.
REQ-031 Frame 0,0,0,1 with din_valid=0 gaps of 2 cycles between samples -> same douts as gap-free, sel frozen during gaps.
REQ-032 Frame 1,1,1,0 stalled by sync=1 at sel=2 -> frame_err pulses, douts hold, sel=1; the following B,C,D complete the new frame.
REQ-033 rst_n low at sel=2, then released; B,C,D without sync -> all discarded in HUNT, sel=0, no frame_valid.
REQ-034 With TDM_DEMUX_ERRCNT_EN, 300 forced framing errors -> err_count = 255.
